// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional range checking is compiled in with DMEM_RANGE_CHECK_EN (see dmem_responder.sv).
package dmem_responder_pkg;

  // Responder FSM: accept in IDLE, count wait states in WAIT, one-cycle ready in DONE
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Latched access type
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Largest wait-state count the 4-bit counter can hold
  localparam int DMEM_LATENCY_MAX = 15;

endpackage

// File: rtl/dmem_array.sv
// Word array behind the responder: single port, synchronous write, registered read.
// Reset clears every word and the read register, so a reset aborts any pending access.
module dmem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  // Read register only moves on a read strobe; otherwise it holds the last load
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[idx];
  end

  // Array and read register update, with a full clear on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rdata_q <= rdata_d;
      if (we) mem_q[idx] <= wdata;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder with a fixed LATENCY-cycle access time.
// A request seen in IDLE raises stall immediately; stall holds through WAIT and drops
// in DONE, where ready pulses once. Inputs are latched at acceptance and ignored after.
// Define DMEM_RANGE_CHECK_EN to flag addresses beyond the array (write dropped, read
// returns 0, range_err pulses with ready); otherwise upper address bits simply wrap.
// LATENCY must lie in 1..DMEM_LATENCY_MAX.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              ready,
  output logic              stall,
  output logic              range_err
);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              op_q, op_d;
  logic              oor_q, oor_d;
  logic              req, accept, fire, addr_oor;
  logic              arr_we, arr_re;
  logic [DATA_W-1:0] arr_rdata;

  assign req    = mem_read | mem_write;
  assign accept = (state_q == IDLE) && req;

`ifdef DMEM_RANGE_CHECK_EN
  assign addr_oor = |addr[31:ADDR_W];
`else
  logic addr_hi_unused;
  assign addr_hi_unused = ^addr[31:ADDR_W];
  assign addr_oor       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: DONE always returns to IDLE, so a held request is re-seen one cycle later
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = (LATENCY == 1) ? DONE : WAIT;
      WAIT:    if (cnt_q == 4'd1) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs; stall is combinational on req so the pipeline holds in the request cycle
  always_comb begin
    ready     = (state_q == DONE);
    stall     = !rst && (accept || (state_q == WAIT));
`ifdef DMEM_RANGE_CHECK_EN
    range_err = (state_q == DONE) && oor_q;
`else
    range_err = 1'b0;
`endif
  end

  // Latch the request at acceptance and count down the wait states
  always_comb begin
    idx_d   = idx_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    oor_d   = oor_q;
    cnt_d   = cnt_q;
    if (accept) begin
      idx_d   = addr[ADDR_W-1:0];
      wdata_d = write_data;
      op_d    = mem_write ? OP_WRITE : OP_READ;
      oor_d   = addr_oor;
      cnt_d   = 4'(LATENCY - 1);
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - 4'd1;
    end else if (state_q == DONE) begin
      cnt_d = '0;
    end
  end

  // Request latch and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      wdata_q <= '0;
      op_q    <= OP_READ;
      oor_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      oor_q   <= oor_d;
      cnt_q   <= cnt_d;
    end
  end

  // The array is touched on the edge that enters DONE. The *_d latch values are used so
  // that LATENCY==1 (IDLE straight to DONE) sees the live request rather than stale latches.
  assign fire   = (state_d == DONE);
  assign arr_we = fire && (op_d == OP_WRITE) && !oor_d;
  assign arr_re = fire && (op_d == OP_READ)  && !oor_d;

  dmem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (arr_we),
    .re   (arr_re),
    .idx  (idx_d),
    .wdata(wdata_d),
    .rdata(arr_rdata)
  );

`ifdef DMEM_RANGE_CHECK_EN
  logic rzero_q, rzero_d;

  // An out-of-range read masks the array output to 0 until the next completed read
  always_comb begin
    rzero_d = rzero_q;
    if (fire && (op_d == OP_READ)) rzero_d = oor_d;
  end

  // Out-of-range read mask register
  always_ff @(posedge clk) begin
    if (rst) rzero_q <= 1'b0;
    else     rzero_q <= rzero_d;
  end

  assign read_data = rzero_q ? '0 : arr_rdata;
`else
  assign read_data = arr_rdata;
`endif

endmodule
